// File: rtl/j_register_if.sv
// Bus-side signals of a j_register: capture data and strobes in, gated stored word out.
// The master drives bus_in/s/e and samples bus_out; the register itself is the slave.
interface j_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_in;
    logic             s;
    logic             e;
    logic [WIDTH-1:0] bus_out;

    modport master (
        output bus_in,
        output s,
        output e,
        input  bus_out
    );

    modport slave (
        input  bus_in,
        input  s,
        input  e,
        output bus_out
    );
endinterface

// File: rtl/j_register.sv
// Byte register with enable-gated output for a wired-OR bus; 1-cycle write latency, output combinational from e.
// No backpressure: capture happens on any edge with s high, and there is no handshake.
module j_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    j_register_if.slave  bus
);
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] mem_d;

    // bus_in only reaches the next-state mux when s is high, so junk on an idle bus never lands.
    always_comb begin
        mem_d = mem_q;
        if (bus.s) begin
            mem_d = bus.bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= RESET_VAL;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Zeros when disabled so several registers can be ORed onto one shared bus.
    assign bus.bus_out = bus.e ? mem_q : '0;
endmodule

// File: tb/tb_j_register.sv
// Directed bench for j_register: stimulus queues expected bus values, a monitor pops and compares them.
module tb_j_register;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    j_register_if #(.WIDTH(8)) if_a ();
    j_register_if #(.WIDTH(8)) if_b ();

    j_register #(.WIDTH(8), .RESET_VAL(8'h00)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    j_register #(.WIDTH(8), .RESET_VAL(8'h5A)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    localparam int SRC_A  = 0;
    localparam int SRC_B  = 1;
    localparam int SRC_OR = 2;

    typedef struct {
        int         src;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Queue one expectation and ask the monitor to sample now, well clear of the rising edge.
    task automatic expect_out(input int src, input logic [7:0] v, input string nm);
        exp_t x;
        x.src  = src;
        x.val  = v;
        x.name = nm;
        exp_q.push_back(x);
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                exp_t       x;
                logic [7:0] act;
                x = exp_q.pop_front();
                case (x.src)
                    SRC_A:   act = if_a.bus_out;
                    SRC_B:   act = if_b.bus_out;
                    default: act = if_a.bus_out | if_b.bus_out;
                endcase
                n_checks++;
                if (act !== x.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", x.name, act, x.val);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        if_a.bus_in = 8'h77;
        if_a.s      = 1'b0;
        if_a.e      = 1'b1;
        if_b.bus_in = 8'h00;
        if_b.s      = 1'b0;
        if_b.e      = 1'b1;

        // Reset: A clears, B loads its own reset value; e gates both.
        tick();
        expect_out(SRC_A, 8'h00, "reset_a_e1");
        expect_out(SRC_B, 8'h5A, "reset_b_e1");
        if_a.e = 1'b0;
        expect_out(SRC_A, 8'h00, "reset_a_e0");

        // Capture 20, then ignore a change on bus_in while s is low.
        reset       = 1'b0;
        if_a.bus_in = 8'd20;
        if_a.s      = 1'b1;
        tick();
        if_a.s = 1'b0;
        if_a.e = 1'b1;
        expect_out(SRC_A, 8'd20, "capture_20");
        if_a.bus_in = 8'd22;
        expect_out(SRC_A, 8'd20, "hold_bus_change");
        tick();
        expect_out(SRC_A, 8'd20, "hold_after_edge");

        // Enable gating within one cycle, no edge in between.
        if_a.bus_in = 8'hA5;
        if_a.s      = 1'b1;
        tick();
        if_a.s = 1'b0;
        expect_out(SRC_A, 8'hA5, "gate_e1");
        if_a.e = 1'b0;
        expect_out(SRC_A, 8'h00, "gate_e0");
        if_a.e = 1'b1;
        expect_out(SRC_A, 8'hA5, "gate_e1_again");

        // s and e together: old word until the edge, new word after.
        if_a.bus_in = 8'h0C;
        if_a.s      = 1'b1;
        tick();
        if_a.bus_in = 8'h2A;
        expect_out(SRC_A, 8'h0C, "se_before_edge");
        tick();
        if_a.s = 1'b0;
        expect_out(SRC_A, 8'h2A, "se_after_edge");

        // Reset beats s on the same edge; capture resumes once reset drops.
        if_a.bus_in = 8'hFF;
        if_a.s      = 1'b1;
        reset       = 1'b1;
        tick();
        expect_out(SRC_A, 8'h00, "reset_over_set");
        reset = 1'b0;
        tick();
        expect_out(SRC_A, 8'hFF, "set_after_reset");

        // Reset held for two edges with s high throughout.
        if_a.bus_in = 8'h33;
        reset       = 1'b1;
        tick();
        expect_out(SRC_A, 8'h00, "midseq_reset_1");
        tick();
        expect_out(SRC_A, 8'h00, "midseq_reset_2");
        reset = 1'b0;
        tick();
        expect_out(SRC_A, 8'h33, "midseq_resume");
        if_a.s = 1'b0;

        // Shared-bus OR of two registers.
        if_a.bus_in = 8'h14;
        if_a.s      = 1'b1;
        if_b.bus_in = 8'h16;
        if_b.s      = 1'b1;
        tick();
        if_a.s = 1'b0;
        if_b.s = 1'b0;
        if_a.e = 1'b1;
        if_b.e = 1'b0;
        expect_out(SRC_OR, 8'h14, "or_a_enabled");
        expect_out(SRC_B, 8'h00, "b_disabled_zero");
        if_a.e = 1'b0;
        if_b.e = 1'b1;
        expect_out(SRC_OR, 8'h16, "or_b_enabled");

        // e tied high: value stays mirrored over idle edges.
        if_a.e = 1'b1;
        tick();
        tick();
        expect_out(SRC_A, 8'h14, "mirror_idle");

        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
